fetch_stage: RTL

RV32I instruction-fetch stage. It sits directly upstream of the decode/register-file stage.
- Owns the PC and issues word fetches to instruction memory over a req/gnt + rvalid handshake.
- Holds one fetched instruction in an output slot that decode consumes with a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and discards any in-flight stale fetch.

---
 rtl/rv_pkg.sv | 14 +
 rtl/fetch_pc_gen.sv | 47 ++++
 rtl/fetch_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: datapath width, canonical NOP and fetch FSM encoding.
package rv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the next fetch PC and the PC of the outstanding request.
module fetch_pc_gen
  import rv_pkg::*;
#(
  parameter int unsigned      XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_advance,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_req_pc,
  output logic [XLEN-1:0] o_req_pc_plus4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_aligned;

  // Unsigned add wraps 0xFFFF_FFFC to 0 naturally.
  assign w_pc_plus4         = r_pc + XLEN'(4);
  assign w_redirect_aligned = {i_redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      if (i_redirect) begin
        r_pc <= w_redirect_aligned;
      end else if (i_advance) begin
        r_pc <= w_pc_plus4;
      end
      if (i_advance) begin
        r_req_pc <= r_pc;
      end
    end
  end

  assign o_pc           = r_pc;
  assign o_req_pc       = r_req_pc;
  assign o_req_pc_plus4 = r_req_pc + XLEN'(4);

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: single-outstanding imem fetch feeding a one-entry valid/ready slot to decode.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned XLEN     = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr
);

  localparam logic [1:0] ST_REQ  = FETCH_REQ;
  localparam logic [1:0] ST_WAIT = FETCH_WAIT;
  localparam logic [1:0] ST_DROP = FETCH_DROP;

  logic [1:0]      r_state;
  logic [1:0]      w_state_d;
  logic            r_run;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc_plus4;
  logic [31:0]     r_id_instr;

  logic            w_slot_free;
  logic            w_req;
  logic            w_fire;
  logic            w_fill;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_req_pc;
  logic [XLEN-1:0] w_req_pc_plus4;

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (XLEN'(RESET_PC))
  ) u_pc_gen (
    .clk            (clk),
    .reset          (reset),
    .i_advance      (w_fire),
    .i_redirect     (redirect_valid),
    .i_redirect_pc  (redirect_pc),
    .o_pc           (w_pc),
    .o_req_pc       (w_req_pc),
    .o_req_pc_plus4 (w_req_pc_plus4)
  );

  // Clears asynchronously so no request is visible while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign w_slot_free = !r_id_valid || id_ready;
  assign w_req       = r_run && (r_state == ST_REQ) && w_slot_free;
  assign w_fire      = w_req && imem_gnt;
  // A response landing with a redirect is already stale.
  assign w_fill      = (r_state == ST_WAIT) && imem_rvalid && !redirect_valid;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_REQ: begin
        if (w_fire) begin
          w_state_d = redirect_valid ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          w_state_d = ST_REQ;
        end else if (redirect_valid) begin
          w_state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          w_state_d = ST_REQ;
        end
      end
      default: w_state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_id_valid    <= 1'b0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= XLEN'(4);
      r_id_instr    <= NOP_INSTR;
    end else begin
      if (redirect_valid) begin
        r_id_valid <= 1'b0;
      end else if (w_fill) begin
        r_id_valid    <= 1'b1;
        r_id_pc       <= w_req_pc;
        r_id_pc_plus4 <= w_req_pc_plus4;
        r_id_instr    <= imem_rdata;
      end else if (r_id_valid && id_ready) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = w_pc;
  assign id_valid    = r_id_valid;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_instr    = r_id_instr;

endmodule
